// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared fib widths, client state encoding and BCD digit-count helper
package fib_pkg;

  localparam int FIB_N_IN  = 7;
  localparam int FIB_N_OUT = 90;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_CLR = 3'd1,
    ST_REQ_ACK = 3'd2,
    ST_REQ_REL = 3'd3,
    ST_CONV    = 3'd4,
    ST_OUT     = 3'd5
  } fib_state_t;

  // Smallest d with 10^d > 2^bits, using log10(2) ~= 0.30103.
  function automatic int bcd_digits_for(input int bits);
    return (bits * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to packed BCD converter, W cycles per value
module bin2bcd_seq #(
  parameter int W = 90,
  parameter int D = 28
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd
);

  localparam int CW = $clog2(W + 1);

  logic [4*D+W-1:0] sh;
  logic [4*D+W-1:0] sh_adj;
  logic [CW-1:0]    cnt;

  always_comb begin
    sh_adj = sh;
    for (int i = 0; i < D; i++) begin
      if (sh[W+4*i +: 4] >= 4'd5) begin
        sh_adj[W+4*i +: 4] = sh[W+4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh   <= {{(4*D){1'b0}}, bin};
        cnt  <= CW'(W);
        busy <= 1'b1;
      end else if (busy) begin
        sh  <= {sh_adj[4*D+W-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Digits are only meaningful in the done cycle; zero otherwise.
  assign bcd = done ? sh[4*D+W-1 -: 4*D] : '0;

endmodule

// File: rtl/fib_bcd_client.sv
// rtl/fib_bcd_client.sv - fib requester: cmd port, four-phase req/ack, BCD conversion, result port
// Optional fib_ack timeout with err output when FIB_BCD_CLIENT_TIMEOUT_EN is defined.
module fib_bcd_client
  import fib_pkg::*;
#(
  parameter int N_IN     = FIB_N_IN,
  parameter int N_OUT    = FIB_N_OUT,
  parameter int N_DIGITS = bcd_digits_for(FIB_N_OUT)
`ifdef FIB_BCD_CLIENT_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [N_IN-1:0]       cmd_n,
  output logic                  fib_req,
  output logic [N_IN-1:0]       fib_n,
  input  logic                  fib_ack,
  input  logic [N_OUT-1:0]      fib_result,
  output logic                  bcd_valid,
  input  logic                  bcd_ready,
  output logic [4*N_DIGITS-1:0] bcd_digits,
  output logic [N_OUT-1:0]      bin_out
`ifdef FIB_BCD_CLIENT_TIMEOUT_EN
  ,
  output logic                  err
`endif
);

  fib_state_t state, next_state;

  logic                  accept;
  logic                  conv_start;
  logic [N_OUT-1:0]      conv_bin;
  logic                  conv_busy;
  logic                  conv_done;
  logic [4*N_DIGITS-1:0] conv_bcd;
  logic                  timeout_hit;

`ifdef FIB_BCD_CLIENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  assign timeout_hit = ((state == ST_REQ_CLR) || (state == ST_REQ_ACK)) && (tcnt == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if ((state == ST_REQ_CLR) || (state == ST_REQ_ACK)) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end else if ((state == ST_OUT) && bcd_ready) begin
        err <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    conv_start = 1'b0;
    conv_bin   = '0;
    case (state)
      ST_IDLE: begin
        accept = cmd_valid && cmd_ready && !conv_busy;
        if (accept) begin
          if (cmd_n != '0) begin
            next_state = ST_REQ_CLR;
          end else begin
            // fib has no n=0 case; convert a literal zero instead.
            conv_start = 1'b1;
            next_state = ST_CONV;
          end
        end
      end
      ST_REQ_CLR: begin
        // A high ack here is left over from the previous transaction.
        if (timeout_hit) next_state = ST_OUT;
        else if (!fib_ack) next_state = ST_REQ_ACK;
      end
      ST_REQ_ACK: begin
        if (timeout_hit) begin
          next_state = ST_OUT;
        end else if (fib_ack) begin
          conv_start = 1'b1;
          conv_bin   = fib_result;
          next_state = ST_REQ_REL;
        end
      end
      ST_REQ_REL: next_state = ST_CONV;
      ST_CONV:    if (conv_done) next_state = ST_OUT;
      ST_OUT:     if (bcd_ready) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b0;
      fib_req    <= 1'b0;
      fib_n      <= '0;
      bcd_valid  <= 1'b0;
      bcd_digits <= '0;
      bin_out    <= '0;
    end else begin
      cmd_ready <= (next_state == ST_IDLE);
      fib_req   <= (next_state == ST_REQ_CLR) || (next_state == ST_REQ_ACK);
      if (accept && (cmd_n != '0)) begin
        fib_n <= cmd_n;
      end
      if (conv_start) begin
        bin_out <= conv_bin;
      end
      if ((state == ST_CONV) && conv_done) begin
        bcd_digits <= conv_bcd;
        bcd_valid  <= 1'b1;
      end
      if (timeout_hit) begin
        bcd_digits <= '0;
        bcd_valid  <= 1'b1;
      end
      if ((state == ST_OUT) && bcd_ready) begin
        bcd_valid <= 1'b0;
      end
    end
  end

  bin2bcd_seq #(
    .W (N_OUT),
    .D (N_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

endmodule

// File: doc/fib_bcd_client.md
Name: fib_bcd_client

Overview:
- Upstream requester and downstream consumer for the fib calculator.
- Accepts an index n on a valid/ready command port and runs the four-phase req/ack handshake with fib.
- Captures the binary result, converts it to packed BCD with a sequential shift-add-3 engine, and presents the digits on a valid/ready output port.
- Sits between the host/command logic and any decimal display or UART formatter.

Parameters:
- N_IN, 7, width of the index n; must match fib.
- N_OUT, 90, width of the fib binary result; must match fib.
- N_DIGITS, 28, number of BCD digits produced; must satisfy 10^N_DIGITS > 2^N_OUT.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_n  in  N_IN  Fibonacci index requested.
- fib_req  out  1  request to fib.
- fib_n  out  N_IN  index to fib; held stable while fib_req=1.
- fib_ack  in  1  fib acknowledge.
- fib_result  in  N_OUT  fib binary result; valid when fib_ack=1.
- bcd_valid  out  1  BCD result present.
- bcd_ready  in  1  sink accepts the result.
- bcd_digits  out  4*N_DIGITS  packed BCD, digit 0 (least significant) in bits [3:0].
- bin_out  out  N_OUT  binary value that was converted, for checking.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; cmd_ready=0, fib_req=0, fib_n=0, bcd_valid=0, bcd_digits=0, bin_out=0; the iteration counter and shift register are cleared.
- Reset mid-operation aborts everything on the next edge. fib_req drops, which lets fib return to its wait state.
- States: IDLE, REQ_CLR, REQ_ACK, REQ_REL, CONV, OUT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_n!=0: latch fib_n=cmd_n, assert fib_req, go to REQ_CLR.
  - On cmd_valid with cmd_n==0: do not issue to fib (fib does not support n=0). Load value 0 and go to CONV.
- REQ_CLR: fib_req=1. Wait for fib_ack==0, then go to REQ_ACK.
  - fib holds ack=1 from the previous transaction until it sees the new req.
  - A high ack on entry must therefore never be treated as completion.
- REQ_ACK: fib_req=1. On fib_ack==1, capture fib_result into bin_out and the shift register, then go to REQ_REL.
- REQ_REL: drop fib_req, then go to CONV on the next cycle.
  - fib_req stays low at least 2 cycles before any new request; the CONV length guarantees this.
- CONV (double dabble):
  - Runs exactly N_OUT iterations, one per cycle.
  - Each iteration first adds 3 to every BCD digit >= 5, then shifts the {bcd, bin} register left by one.
  - The digit register is 4*N_DIGITS bits wide with no overflow; the parameter constraint guarantees this.
  - After the last iteration, load bcd_digits and set bcd_valid=1.
  - Latency from capture to bcd_valid = N_OUT+1 cycles.
- OUT:
  - bcd_valid=1; bcd_digits and bin_out are held stable.
  - On bcd_valid&bcd_ready: clear bcd_valid and go to IDLE; cmd_ready rises the next cycle.
- cmd_ready=1 only in IDLE. No command buffering: at most one command is in flight.
- Outputs are registered; there is no combinational path from any input to any output.

Optional Feature:
- Macro FIB_BCD_CLIENT_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 255) and output port err (1 bit, reset 0).
  - A cycle counter runs in REQ_CLR and REQ_ACK. On reaching TIMEOUT: drop fib_req, set bcd_valid=1, err=1, bcd_digits=0, and go to OUT.
  - err clears when the result is accepted.
- When undefined:
  - No counter and no err port.
  - The block waits indefinitely for fib_ack.

Decomposition:
- Shared package fib_pkg:
  - State encoding localparams (IDLE..OUT).
  - Default N_IN/N_OUT shared with fib.
  - Derived digit-count helper.
- One sub-module, bin2bcd_seq. It is the shift-add-3 engine with start/busy/done, a parameterised width, and a done-qualified output, so it can be reused by other formatters.

Test Plan:
- cmd_n=10 against a fib instance -> exactly one fib_req rise; bcd_digits=0x...0055; bin_out=55; bcd_valid arrives N_OUT+1 cycles after ack capture.
- cmd_n=0 -> fib_req never asserts; bcd_digits=0; bin_out=0; bcd_valid after N_OUT+1 cycles.
- cmd_n=1 then cmd_n=90 back-to-back (stale ack=1 held from the first) -> second result is 2880067194370816120 in BCD; no early capture on the stale ack.
- cmd_n=127 -> bcd_digits = 155576970220531065681649693 (27 digits; top digit 0); all digits <= 9.
- bcd_ready held low for 20 cycles -> bcd_valid, bcd_digits and bin_out stable; cmd_ready=0 throughout.
- rst_n=0 for one cycle while in REQ_ACK -> next cycle fib_req=0, bcd_valid=0, cmd_ready=0 until reset releases.
- With FIB_BCD_CLIENT_TIMEOUT_EN and fib_ack tied 0 -> err=1 and bcd_digits=0 after TIMEOUT cycles; fib_req low.
